// File: rtl/caravel_timer.sv
// Caravel management SoC 32-bit counter/timer with a word-addressed register bus.
// Counts up or down, one-shot or continuous, and raises a level interrupt on terminal count.
module caravel_timer #(
    parameter logic [31:0] RESET_DATA = 32'h0
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic [1:0]  reg_addr,
    input  logic        reg_we,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        timer_irq
);

    localparam logic [1:0] ADDR_CONFIG = 2'd0;
    localparam logic [1:0] ADDR_VALUE  = 2'd1;
    localparam logic [1:0] ADDR_DATA   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    logic [3:0]  cfg;
    logic [31:0] value;
    logic [31:0] data;
    logic        pending;
    logic        held;

    logic        cfg_enable;
    logic        cfg_oneshot;
    logic        cfg_up;
    logic        cfg_irq_ena;

    logic        wr_config;
    logic        wr_value;
    logic        wr_data;
    logic        wr_status;
    logic        at_term;
    logic        term_event;
    logic [31:0] value_nxt;

    assign cfg_enable  = cfg[0];
    assign cfg_oneshot = cfg[1];
    assign cfg_up      = cfg[2];
    assign cfg_irq_ena = cfg[3];

    assign wr_config = reg_we && (reg_addr == ADDR_CONFIG);
    assign wr_value  = reg_we && (reg_addr == ADDR_VALUE);
    assign wr_data   = reg_we && (reg_addr == ADDR_DATA);
    assign wr_status = reg_we && (reg_addr == ADDR_STATUS);

    assign at_term = cfg_up ? (value == data) : (value == 32'h0);

    // A one-shot parked at terminal count must not keep re-firing; held marks that it already has.
    assign term_event = cfg_enable && at_term && !(cfg_oneshot && held);

    always_comb begin
        value_nxt = value;
        if (wr_value) begin
            value_nxt = reg_wdata;
        end else if (cfg_enable) begin
            if (!at_term) begin
                value_nxt = cfg_up ? (value + 32'd1) : (value - 32'd1);
            end else if (!cfg_oneshot) begin
                value_nxt = cfg_up ? 32'h0 : data;
            end
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            cfg     <= 4'h0;
            value   <= 32'h0;
            data    <= RESET_DATA;
            pending <= 1'b0;
            held    <= 1'b0;
        end else begin
            if (wr_config) begin
                cfg <= reg_wdata[3:0];
            end
            if (wr_data) begin
                data <= reg_wdata;
            end
            value <= value_nxt;
            held  <= cfg_enable && cfg_oneshot && at_term && !wr_value;
            // A terminal event in the same cycle as a clear request leaves pending set.
            if (term_event) begin
                pending <= 1'b1;
            end else if (wr_status && reg_wdata[0]) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        reg_rdata = 32'h0;
        case (reg_addr)
            ADDR_CONFIG: reg_rdata = {28'h0, cfg};
            ADDR_VALUE:  reg_rdata = value;
            ADDR_DATA:   reg_rdata = data;
            ADDR_STATUS: reg_rdata = {31'h0, pending};
            default:     reg_rdata = 32'h0;
        endcase
    end

    assign timer_irq = pending && cfg_irq_ena;

endmodule

// File: tb/tb_caravel_timer.sv
// Directed self-checking bench for caravel_timer: hold, one-shot, continuous up/down,
// interrupt clear, VALUE overwrite, wrap-through counting and asynchronous reset.
module tb_caravel_timer;

    localparam logic [31:0] TB_RESET_DATA = 32'h0000_abcd;
    localparam logic [1:0]  A_CFG  = 2'd0;
    localparam logic [1:0]  A_VAL  = 2'd1;
    localparam logic [1:0]  A_DAT  = 2'd2;
    localparam logic [1:0]  A_STS  = 2'd3;

    logic        clock;
    logic        resetb;
    logic [1:0]  reg_addr;
    logic        reg_we;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        timer_irq;

    int n_cmp;
    int n_err;

    caravel_timer #(.RESET_DATA(TB_RESET_DATA)) dut (
        .clock     (clock),
        .resetb    (resetb),
        .reg_addr  (reg_addr),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .timer_irq (timer_irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Write lands on the next rising edge; returns 1 time unit after that edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clock);
        reg_addr  = a;
        reg_wdata = d;
        reg_we    = 1'b1;
        @(posedge clock);
        #1;
        reg_we    = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        reg_addr = a;
        #1;
        chk(tag, reg_rdata, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        resetb    = 1'b0;
        reg_addr  = 2'd0;
        reg_we    = 1'b0;
        reg_wdata = 32'h0;
        cycles(2);
        @(negedge clock);
        resetb = 1'b1;
        cycles(1);

        rd_chk("rst_config", A_CFG, 32'h0);
        rd_chk("rst_value",  A_VAL, 32'h0);
        rd_chk("rst_data",   A_DAT, TB_RESET_DATA);
        rd_chk("rst_status", A_STS, 32'h0);
        chk("rst_irq", {31'h0, timer_irq}, 32'h0);

        // Hold with enable=0, and reserved CONFIG bits ignored
        wr(A_VAL, 32'hdcba7cfb);
        cycles(100);
        rd_chk("hold_value", A_VAL, 32'hdcba7cfb);
        wr(A_CFG, 32'hffff_fff0);
        rd_chk("cfg_reserved", A_CFG, 32'h0);
        wr(A_DAT, 32'h1234_5678);
        rd_chk("data_no_touch_value", A_VAL, 32'hdcba7cfb);
        rd_chk("data_readback", A_DAT, 32'h1234_5678);

        // Down one-shot
        wr(A_VAL, 32'h19);
        wr(A_CFG, 32'h3);
        cycles(24);
        rd_chk("os_value_24", A_VAL, 32'h1);
        rd_chk("os_pend_24",  A_STS, 32'h0);
        cycles(1);
        rd_chk("os_value_25", A_VAL, 32'h0);
        cycles(5);
        rd_chk("os_value_hold", A_VAL, 32'h0);
        rd_chk("os_pending",    A_STS, 32'h1);
        chk("os_irq_masked", {31'h0, timer_irq}, 32'h0);
        rd_chk("os_cfg_kept",   A_CFG, 32'h3);
        wr(A_STS, 32'h0);
        rd_chk("sts_wr0_noeffect", A_STS, 32'h1);
        wr(A_STS, 32'h1);
        cycles(5);
        rd_chk("os_no_refire", A_STS, 32'h0);
        rd_chk("os_still_0",   A_VAL, 32'h0);

        // Up continuous
        wr(A_CFG, 32'h0);
        wr(A_DAT, 32'h0f);
        wr(A_VAL, 32'h0);
        wr(A_CFG, 32'h5);
        rd_chk("up_value_0", A_VAL, 32'h0);
        for (int k = 1; k <= 20; k++) begin
            cycles(1);
            rd_chk($sformatf("up_value_%0d", k), A_VAL, 32'(k % 16));
            if (k == 15) rd_chk("up_pend_before", A_STS, 32'h0);
            if (k == 16) rd_chk("up_pend_after",  A_STS, 32'h1);
        end
        wr(A_STS, 32'h1);
        rd_chk("up_clr_value", A_VAL, 32'h5);
        rd_chk("up_clr_pend",  A_STS, 32'h0);
        cycles(9);
        rd_chk("up_value_14", A_VAL, 32'he);
        rd_chk("up_pend_14",  A_STS, 32'h0);
        cycles(2);
        rd_chk("up_value_wrap", A_VAL, 32'h0);
        rd_chk("up_pend_again", A_STS, 32'h1);
        chk("up_irq_masked", {31'h0, timer_irq}, 32'h0);

        // Down continuous with interrupt
        wr(A_CFG, 32'h0);
        wr(A_STS, 32'h1);
        wr(A_DAT, 32'h12bc);
        wr(A_VAL, 32'h0);
        wr(A_CFG, 32'h9);
        chk("dn_irq_initial", {31'h0, timer_irq}, 32'h0);
        cycles(1);
        rd_chk("dn_reload", A_VAL, 32'h12bc);
        chk("dn_irq_set", {31'h0, timer_irq}, 32'h1);
        wr(A_STS, 32'h1);
        chk("dn_irq_clr", {31'h0, timer_irq}, 32'h0);
        rd_chk("dn_value_after_clr", A_VAL, 32'h12bb);
        cycles(32'h12bb);
        rd_chk("dn_value_zero", A_VAL, 32'h0);
        chk("dn_irq_still_low", {31'h0, timer_irq}, 32'h0);
        cycles(1);
        chk("dn_irq_next_zero", {31'h0, timer_irq}, 32'h1);
        rd_chk("dn_reload2", A_VAL, 32'h12bc);

        // VALUE write while counting
        wr(A_VAL, 32'h100);
        rd_chk("vw_value", A_VAL, 32'h100);
        cycles(1);
        rd_chk("vw_cont1", A_VAL, 32'hff);
        cycles(3);
        rd_chk("vw_cont4", A_VAL, 32'hfc);

        // Up count starting above DATA wraps through 2^32
        wr(A_CFG, 32'h0);
        wr(A_DAT, 32'h10);
        wr(A_VAL, 32'hffff_fffe);
        wr(A_CFG, 32'h5);
        cycles(1);
        rd_chk("wrap_ffffffff", A_VAL, 32'hffff_ffff);
        cycles(1);
        rd_chk("wrap_zero", A_VAL, 32'h0);

        // Asynchronous reset mid-count with interrupt asserted
        wr(A_STS, 32'h1);
        wr(A_CFG, 32'h9);
        wr(A_VAL, 32'h0);
        cycles(1);
        chk("ar_irq_before", {31'h0, timer_irq}, 32'h1);
        #2;
        resetb = 1'b0;
        #1;
        chk("ar_irq", {31'h0, timer_irq}, 32'h0);
        rd_chk("ar_value",  A_VAL, 32'h0);
        rd_chk("ar_config", A_CFG, 32'h0);
        rd_chk("ar_data",   A_DAT, TB_RESET_DATA);
        cycles(3);
        @(negedge clock);
        resetb = 1'b1;
        cycles(10);
        rd_chk("ar_no_count", A_VAL, 32'h0);
        rd_chk("ar_status",   A_STS, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
